regvec_rr_write_arbiter: RTL and testbench



---
 rtl/regvec_rr_write_arbiter_if.sv | 27 ++
 rtl/regvec_rr_write_arbiter.sv | 111 +++++++++++
 tb/tb_regvec_rr_write_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/regvec_rr_write_arbiter_if.sv
// Write-request bus, clear control and flattened register vector of the
// round-robin register-vector writer.
interface regvec_rr_write_arbiter_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3,
  parameter int NREQ  = 2,
  parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*IDXW-1:0]  req_idx;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  clear_start;
  logic                  busy;
  logic                  err_oob;
  logic [DEPTH*WIDTH-1:0] vec_out;

  modport master (
    output req_valid, req_idx, req_data, clear_start,
    input  req_ready, busy, err_oob, vec_out
  );

  modport slave (
    input  req_valid, req_idx, req_data, clear_start,
    output req_ready, busy, err_oob, vec_out
  );
endinterface

// File: rtl/regvec_rr_write_arbiter.sv
// Register vector with round-robin arbitrated single-write-per-cycle access
// and a sequenced one-entry-per-cycle clear.
module regvec_rr_write_arbiter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3,
  parameter int NREQ  = 2
) (
  input logic clk,
  input logic rst,
  regvec_rr_write_arbiter_if.slave bus
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   cnt_reg, cnt_next;
  logic [PTRW-1:0]   ptr_reg, ptr_adv;
  logic              err_oob_reg;
  logic [WIDTH-1:0]  vec_reg [DEPTH];

  logic [NREQ-1:0]   grant_vec;
  logic [IDXW-1:0]   wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_oob;
  logic              accept;
  int                j;

  // State register, clear counter, rr pointer and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      err_oob_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_oob_reg <= accept && wr_oob;
      if (accept)
        ptr_reg <= ptr_adv;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.clear_start)
          state_next = CLEAR;
      end
      CLEAR: begin
        if (cnt_reg == IDXW'(DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // First valid requester at or after ptr, wrapping; winner's fields muxed out
  always_comb begin
    grant_vec = '0;
    wr_idx    = '0;
    wr_data   = '0;
    ptr_adv   = ptr_reg;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_reg) + k) % NREQ;
      if (grant_vec == '0 && bus.req_valid[j]) begin
        grant_vec[j] = 1'b1;
        wr_idx       = bus.req_idx[j*IDXW +: IDXW];
        wr_data      = bus.req_data[j*WIDTH +: WIDTH];
        ptr_adv      = PTRW'((j + 1) % NREQ);
      end
    end
  end

  assign wr_oob = (int'(wr_idx) >= DEPTH);

  always_comb begin
    bus.busy      = (state_reg == CLEAR);
    bus.req_ready = '0;
    if (state_reg == IDLE && !bus.clear_start)
      bus.req_ready = grant_vec;
  end

  assign accept      = |bus.req_ready;
  assign bus.err_oob = err_oob_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst)
          vec_reg[gi] <= '0;
        else if (state_reg == CLEAR && cnt_reg == IDXW'(gi))
          vec_reg[gi] <= '0;
        else if (accept && wr_idx == IDXW'(gi))
          vec_reg[gi] <= wr_data;
      end
      assign bus.vec_out[gi*WIDTH +: WIDTH] = vec_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_regvec_rr_write_arbiter.sv
// Directed plan scenarios followed by random traffic, all checked against an
// array-based reference model of the register vector and arbiter.
module tb_regvec_rr_write_arbiter;
  localparam int WIDTH = 3;
  localparam int DEPTH = 3;
  localparam int NREQ  = 2;
  localparam int IDXW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regvec_rr_write_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .IDXW(IDXW)) bus ();

  regvec_rr_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int m_vec [DEPTH];
  int m_ptr;
  int m_clear_left;
  int m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) m_vec[e] = 0;
    m_ptr = 0;
    m_clear_left = 0;
    m_err = 0;
  endtask

  // One clock cycle: drive, check against model, advance model past the edge
  task automatic cyc(input bit r, input bit [1:0] v, input int i0, input int d0,
                     input int i1, input int d1, input bit cs);
    int g;
    int exp_vec;
    int idx [NREQ];
    int dat [NREQ];
    @(posedge clk);
    #1;
    idx[0] = i0; idx[1] = i1; dat[0] = d0; dat[1] = d1;
    rst             = r;
    bus.req_valid   = v;
    bus.req_idx     = {IDXW'(i1), IDXW'(i0)};
    bus.req_data    = {WIDTH'(d1), WIDTH'(d0)};
    bus.clear_start = cs;
    #3;
    g = -1;
    if (m_clear_left == 0 && !cs)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_vec = 0;
    for (int e = 0; e < DEPTH; e++) exp_vec += m_vec[e] << (e * WIDTH);
    chk("ready", 32'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
    chk("busy", 32'(bus.busy), 32'(m_clear_left > 0));
    chk("err_oob", 32'(bus.err_oob), 32'(m_err));
    chk("vec", 32'(bus.vec_out), exp_vec);
    $display("cyc rst=%0b v=%b cs=%0b ready=%b busy=%0b err=%0b vec=%h",
             r, v, cs, bus.req_ready, bus.busy, bus.err_oob, bus.vec_out);
    if (r) begin
      model_reset();
    end else if (m_clear_left > 0) begin
      m_vec[DEPTH - m_clear_left] = 0;
      m_clear_left--;
      m_err = 0;
    end else if (cs) begin
      m_clear_left = DEPTH;
      m_err = 0;
    end else if (g >= 0) begin
      if (idx[g] < DEPTH) begin
        m_vec[idx[g]] = dat[g];
        m_err = 0;
      end else begin
        m_err = 1;
      end
      m_ptr = (g + 1) % NREQ;
    end else begin
      m_err = 0;
    end
  endtask

  task automatic idle();
    cyc(0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_idx = '0;
    bus.req_data = '0;
    bus.clear_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // 1: reset state, single write
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 2'b01, 1, 5, 0, 0, 0);
    chk("t1_ready", 32'(bus.req_ready), 32'b01);
    idle();
    chk("t1_vec", 32'(bus.vec_out), 32'h028);

    // 2: both valid, alternating grants
    for (int n = 0; n < 4; n++) cyc(0, 2'b11, 0, 1, 2, 6, 0);
    idle();
    chk("t2_vec", 32'(bus.vec_out), 32'h1A9);

    // 3: clear beats a request, then r0 served first
    for (int e = 0; e < DEPTH; e++) cyc(0, 2'b01, e, 7, 0, 0, 0);
    cyc(0, 2'b01, 0, 7, 0, 0, 1);
    chk("t3_noclr_grant", 32'(bus.req_ready), 0);
    for (int n = 0; n < DEPTH; n++) cyc(0, 2'b01, 1, 2, 0, 0, 1);
    cyc(0, 2'b01, 1, 2, 0, 0, 0);
    chk("t3_after_clr", 32'(bus.req_ready), 32'b01);

    // 4: out-of-range write from r1
    cyc(0, 2'b10, 0, 0, 3, 4, 0);
    chk("t4_ready", 32'(bus.req_ready), 32'b10);
    idle();
    chk("t4_err", 32'(bus.err_oob), 1);
    idle();
    chk("t4_err_once", 32'(bus.err_oob), 0);

    // 5: reset during clear cycle 1
    cyc(0, 2'b01, 1, 5, 0, 0, 0);
    cyc(0, 2'b01, 2, 5, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 1);
    idle();
    cyc(1, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 2'b11, 0, 3, 1, 3, 0);
    chk("t5_vec", 32'(bus.vec_out), 0);
    chk("t5_r0_first", 32'(bus.req_ready), 32'b01);

    // 6: lone r1 gets every cycle
    for (int n = 0; n < 3; n++) begin
      cyc(0, 2'b10, 0, 0, n % DEPTH, n + 1, 0);
      chk("t6_ready", 32'(bus.req_ready), 32'b10);
    end

    // Random traffic
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 49) == 0), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 11) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
